// File: rtl/rsa_modexp_seq_if.sv
// Handshake/operand bundle for rsa_modexp_seq.
//   master: drives start, mode, base, exp, modulus; observes busy, done, result, err, dec_en
//   slave : the engine side (inverse directions)
interface rsa_modexp_seq_if #(
    parameter int unsigned W = 4
);
    logic         start;
    logic         mode;
    logic [W-1:0] base;
    logic [W-1:0] exp;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;
    logic         dec_en;

    modport master (
        output start, mode, base, exp, modulus,
        input  busy, done, result, err, dec_en
    );

    modport slave (
        input  start, mode, base, exp, modulus,
        output busy, done, result, err, dec_en
    );
endinterface

// File: rtl/rsa_modexp_seq.sv
// Sequential square-and-multiply modular exponentiation: result = base^exp mod modulus.
// Fixed latency per run (every exponent bit runs both square and multiply paths).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any run in progress
//   bus    slave side of rsa_modexp_seq_if (start/mode/base/exp/modulus in;
//          busy/done/result/err/dec_en out, all registered)
module rsa_modexp_seq #(
    parameter int unsigned W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rsa_modexp_seq_if.slave     bus
);
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(PW);
    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRERED, S_SQ_MUL, S_SQ_RED, S_MU_MUL, S_MU_RED, S_NEXT, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W-1:0]    mod_q, mod_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic [W-1:0]    r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic            err_run_q, err_run_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            err_q, err_d;
    logic            dec_en_q, dec_en_d;

    logic [W:0]      r_sh;
    logic [W-1:0]    r_step;
    logic            red_last;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            exp_q     <= '0;
            mod_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            p_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            err_run_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            dec_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            exp_q     <= exp_d;
            mod_q     <= mod_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            err_run_q <= err_run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            err_q     <= err_d;
            dec_en_q  <= dec_en_d;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        exp_d     = exp_q;
        mod_d     = mod_q;
        b_d       = b_q;
        acc_d     = acc_q;
        p_d       = p_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        err_run_d = err_run_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        err_d     = err_q;
        dec_en_d  = dec_en_q;

        // One restoring shift-subtract step; r < modulus before the shift, so one subtract suffices
        r_sh = {r_q, p_q[PW-1]};
        if (r_sh >= {1'b0, mod_q}) begin
            r_step = W'(r_sh - {1'b0, mod_q});
        end else begin
            r_step = W'(r_sh);
        end
        red_last = (cnt_q == CW'(PW - 1));

        if (state_q == S_PRERED || state_q == S_SQ_RED || state_q == S_MU_RED) begin
            p_d   = {p_q[PW-2:0], 1'b0};
            r_d   = r_step;
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode;
                    exp_d     = bus.exp;
                    mod_d     = bus.modulus;
                    p_d       = PW'(bus.base);
                    r_d       = '0;
                    cnt_d     = '0;
                    k_d       = KW'(W - 1);
                    busy_d    = 1'b1;
                    err_run_d = (bus.modulus == '0);
                    state_d   = (bus.modulus == '0) ? S_FIN : S_PRERED;
                end
            end
            S_PRERED: begin
                if (red_last) begin
                    b_d     = r_step;
                    acc_d   = (mod_q == W'(1)) ? '0 : W'(1);
                    state_d = S_SQ_MUL;
                end
            end
            S_SQ_MUL: begin
                p_d     = PW'(acc_q) * PW'(acc_q);
                r_d     = '0;
                cnt_d   = '0;
                state_d = S_SQ_RED;
            end
            S_SQ_RED: begin
                if (red_last) begin
                    acc_d   = r_step;
                    state_d = S_MU_MUL;
                end
            end
            S_MU_MUL: begin
                p_d     = PW'(acc_q) * PW'(b_q);
                r_d     = '0;
                cnt_d   = '0;
                state_d = S_MU_RED;
            end
            S_MU_RED: begin
                // Product is always reduced; it is only kept when the exponent bit is set
                if (red_last) begin
                    if (exp_q[k_q]) begin
                        acc_d = r_step;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (k_q == '0) begin
                    result_d = acc_q;
                    err_d    = 1'b0;
                    dec_en_d = mode_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_FIN;
                end else begin
                    k_d     = k_q - KW'(1);
                    state_d = S_SQ_MUL;
                end
            end
            S_FIN: begin
                // Normal runs publish on entry to FIN; the zero-modulus run publishes on exit
                if (err_run_q) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    dec_en_d = 1'b0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
    assign bus.dec_en = dec_en_q;

endmodule
